// File: rtl/bar_pkg.sv
// Shared types and constants for the 10-switch thermometer bar and its 0..10 level code.
package bar_pkg;

  localparam int BAR_W   = 10;
  localparam int LEVEL_W = 4;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd10;

  typedef logic [LEVEL_W-1:0] level_t;
  typedef logic [BAR_W-1:0]   bar_t;

  typedef enum logic {
    IDLE,
    PEND
  } report_state_t;

  // One reported word; level and bubble are always compared and sent together.
  typedef struct packed {
    level_t level;
    logic   bubble;
  } report_t;

  // LED bar decoder: level n lights the bottom n segments.
  function automatic bar_t led_decode(input level_t lvl);
    bar_t bar;
    bar = '0;
    for (int i = 0; i < BAR_W; i++) begin
      if (i < int'(lvl)) bar[i] = 1'b1;
    end
    return bar;
  endfunction

endpackage

// File: rtl/switch_level_encoder_if.sv
// Valid/ready word channel from the switch encoder towards the UART transmit path.
interface switch_level_encoder_if;
  import bar_pkg::*;

  level_t level;
  logic   bubble;
  logic   out_valid;
  logic   out_ready;

  modport master (output level, output bubble, output out_valid, input out_ready);
  modport slave  (input level, input bubble, input out_valid, output out_ready);

endinterface

// File: rtl/therm_encoder.sv
// Thermometer bar to level: count of contiguous ones from bit 0, plus a bubble flag
// for any one lying above the first zero.
module therm_encoder
  import bar_pkg::*;
(
  input  bar_t   bar,
  output level_t level,
  output logic   bubble
);

  logic seen_zero;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    level     = '0;
    bubble    = 1'b0;
    seen_zero = 1'b0;
    for (int i = 0; i < BAR_W; i++) begin
      if (!bar[i]) begin
        seen_zero = 1'b1;
      end else if (seen_zero) begin
        bubble = 1'b1;
      end else begin
        level = LEVEL_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/switch_level_encoder.sv
// Synchronises and debounces the slide switches as one vector, encodes the bar to a
// level, and reports each new level (latest value wins) on a valid/ready channel.
module switch_level_encoder
  import bar_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  bar_t sw_raw,
  output bar_t stable_bar,
  switch_level_encoder_if.master tx
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  bar_t             s1, s2;
  logic [1:0]       sync_fill;
  logic [CNT_W-1:0] cnt;
  logic             primed;

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= '0;
      s2         <= '0;
      sync_fill  <= '0;
      cnt        <= '0;
      stable_bar <= '0;
      primed     <= 1'b0;
    end else begin
      s1        <= sw_raw;
      s2        <= s1;
      sync_fill <= {sync_fill[0], 1'b1};
      // s2 is about to change (or the synchroniser is still refilling after reset)
      if (!sync_fill[1] || (s1 != s2)) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
      // The first settle after reset always loads so the forced report sees settled switches.
      if ((cnt == CNT_MAX) && ((s2 != stable_bar) || !primed)) begin
        stable_bar <= s2;
        primed     <= 1'b1;
      end
    end
  end

  report_t enc;

  therm_encoder u_therm_encoder (
    .bar    (stable_bar),
    .level  (enc.level),
    .bubble (enc.bubble)
  );

  report_state_t state, state_nx;
  report_t       word_q, word_nx;
  report_t       last_sent, last_sent_nx;
  logic          force_report, force_report_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      word_q       <= '0;
      last_sent    <= '0;
      force_report <= 1'b1;
    end else begin
      state        <= state_nx;
      word_q       <= word_nx;
      last_sent    <= last_sent_nx;
      force_report <= force_report_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    word_nx         = word_q;
    last_sent_nx    = last_sent;
    force_report_nx = force_report;
    unique case (state)
      IDLE: begin
        if (primed && ((enc != last_sent) || force_report)) begin
          state_nx = PEND;
          word_nx  = enc;
        end
      end
      PEND: begin
        if (tx.out_ready) begin
          state_nx        = IDLE;
          last_sent_nx    = word_q;
          force_report_nx = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign tx.out_valid = (state == PEND);
  assign tx.level     = word_q.level;
  assign tx.bubble    = word_q.bubble;

endmodule

// File: tb/tb_switch_level_encoder.sv
// Directed bench: table-driven encoder vectors, LED decoder round trip, and
// hand-written debounce/handshake/reset sequences with DEBOUNCE_CYCLES = 4.
module tb_switch_level_encoder;
  import bar_pkg::*;

  localparam int DEB = 4;
  localparam int LAT = DEB + 3;

  logic clk = 1'b0;
  logic rst;
  bar_t sw_raw;
  bar_t stable_bar;

  bar_t   enc_bar;
  level_t enc_level;
  logic   enc_bubble;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  switch_level_encoder_if bus ();

  switch_level_encoder #(
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_raw     (sw_raw),
    .stable_bar (stable_bar),
    .tx         (bus)
  );

  therm_encoder u_enc (
    .bar    (enc_bar),
    .level  (enc_level),
    .bubble (enc_bubble)
  );

  typedef struct {
    bar_t   bar;
    level_t level;
    logic   bubble;
  } enc_vec_t;

  enc_vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Count edges until out_valid is seen high; stops at the budget.
  task automatic wait_valid(input int budget, output int edges);
    edges = 0;
    do begin
      step(1);
      edges++;
    end while (!bus.out_valid && edges < budget);
  endtask

  // Watch for any word over n cycles; returns 1 if out_valid was ever seen.
  task automatic watch_quiet(input int n, output int seen);
    seen = 0;
    repeat (n) begin
      step(1);
      if (bus.out_valid) seen = 1;
    end
  endtask

  initial begin
    int edges;
    int seen;
    int held_ok;

    vecs[0]  = '{10'h000, 4'd0,  1'b0};
    vecs[1]  = '{10'h001, 4'd1,  1'b0};
    vecs[2]  = '{10'h007, 4'd3,  1'b0};
    vecs[3]  = '{10'h00B, 4'd2,  1'b1};
    vecs[4]  = '{10'h1FF, 4'd9,  1'b0};
    vecs[5]  = '{10'h3FF, 4'd10, 1'b0};
    vecs[6]  = '{10'h200, 4'd0,  1'b1};
    vecs[7]  = '{10'h002, 4'd0,  1'b1};
    vecs[8]  = '{10'h2FF, 4'd8,  1'b1};
    vecs[9]  = '{10'h3FE, 4'd0,  1'b1};
    vecs[10] = '{10'h0F0, 4'd0,  1'b1};
    vecs[11] = '{10'h17F, 4'd7,  1'b1};

    rst           = 1'b1;
    sw_raw        = '0;
    bus.out_ready = 1'b0;
    enc_bar       = '0;

    // Standalone encoder vectors
    for (int i = 0; i < 12; i++) begin
      enc_bar = vecs[i].bar;
      #1;
      check($sformatf("enc_level[%0d]", i), int'(enc_level), int'(vecs[i].level));
      check($sformatf("enc_bubble[%0d]", i), int'(enc_bubble), int'(vecs[i].bubble));
    end

    // LED decoder followed by encoder returns the original level
    for (int i = 0; i <= int'(LEVEL_MAX); i++) begin
      enc_bar = led_decode(level_t'(i));
      #1;
      check($sformatf("roundtrip_level[%0d]", i), int'(enc_level), i);
      check($sformatf("roundtrip_bubble[%0d]", i), int'(enc_bubble), 0);
    end

    // Reset with switches at 0: outputs clear, one forced report of level 0
    step(3);
    check("rst_stable_bar", int'(stable_bar), 0);
    check("rst_level", int'(bus.level), 0);
    check("rst_bubble", int'(bus.bubble), 0);
    check("rst_valid", int'(bus.out_valid), 0);
    rst = 1'b0;
    wait_valid(30, edges);
    check("first_report_latency", edges, LAT);
    check("first_report_level", int'(bus.level), 0);
    check("first_report_bubble", int'(bus.bubble), 0);
    bus.out_ready = 1'b1;
    step(1);
    check("first_report_accept", int'(bus.out_valid), 0);
    watch_quiet(20, seen);
    check("no_repeat_after_first", seen, 0);

    // Level 3, ready held high
    sw_raw = 10'h007;
    wait_valid(30, edges);
    check("lvl3_latency", edges, LAT);
    check("lvl3_level", int'(bus.level), 3);
    check("lvl3_bubble", int'(bus.bubble), 0);
    check("lvl3_stable_bar", int'(stable_bar), 'h007);
    step(1);
    check("lvl3_accept", int'(bus.out_valid), 0);

    // Three-cycle glitch to all-ones is filtered out
    sw_raw = 10'h3FF;
    step(3);
    sw_raw = 10'h007;
    watch_quiet(20, seen);
    check("glitch_no_word", seen, 0);
    check("glitch_stable_bar", int'(stable_bar), 'h007);

    // Bubble pattern then full bar
    sw_raw = 10'h00B;
    wait_valid(30, edges);
    check("bubble_latency", edges, LAT);
    check("bubble_level", int'(bus.level), 2);
    check("bubble_flag", int'(bus.bubble), 1);
    sw_raw = 10'h3FF;
    wait_valid(30, edges);
    check("full_level", int'(bus.level), 10);
    check("full_bubble", int'(bus.bubble), 0);
    step(1);

    // Backpressure: pending word holds while switches move on; latest value follows
    bus.out_ready = 1'b0;
    sw_raw = 10'h00F;
    wait_valid(30, edges);
    check("bp_latency", edges, LAT);
    check("bp_level", int'(bus.level), 4);
    sw_raw  = 10'h01F;
    held_ok = 1;
    repeat (20) begin
      step(1);
      if (!bus.out_valid || bus.level != 4'd4) held_ok = 0;
    end
    check("bp_word_held", held_ok, 1);
    check("bp_stable_bar", int'(stable_bar), 'h01F);
    bus.out_ready = 1'b1;
    step(1);
    check("bp_gap_low", int'(bus.out_valid), 0);
    step(1);
    check("bp_next_valid", int'(bus.out_valid), 1);
    check("bp_next_level", int'(bus.level), 5);
    step(1);
    check("bp_next_accept", int'(bus.out_valid), 0);

    // Reset mid-debounce (counter at 2)
    sw_raw = 10'h07F;
    step(4);
    rst = 1'b1;
    step(1);
    check("rst_mid_deb_stable", int'(stable_bar), 0);
    check("rst_mid_deb_valid", int'(bus.out_valid), 0);
    rst = 1'b0;
    wait_valid(30, edges);
    check("rst_mid_deb_latency", edges, LAT);
    check("rst_mid_deb_level", int'(bus.level), 7);
    step(1);

    // Reset while a word is pending
    bus.out_ready = 1'b0;
    sw_raw = 10'h003;
    wait_valid(30, edges);
    check("pend_level", int'(bus.level), 2);
    step(2);
    rst = 1'b1;
    step(1);
    check("rst_pend_valid", int'(bus.out_valid), 0);
    check("rst_pend_level", int'(bus.level), 0);
    check("rst_pend_stable", int'(stable_bar), 0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    wait_valid(30, edges);
    check("rst_pend_latency", edges, LAT);
    check("rst_pend_fresh_level", int'(bus.level), 2);
    check("rst_pend_fresh_bubble", int'(bus.bubble), 0);
    step(1);
    check("rst_pend_accept", int'(bus.out_valid), 0);
    watch_quiet(20, seen);
    check("rst_pend_single_word", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
